rx_fifo_ctrl: RTL and testbench
===============================

# rx_fifo_ctrl

Controller for the receive FIFO (FIFO18E1 instance, synchronous mode, 36-bit, non-FWFT, output register enabled). Sequences the FIFO's mandatory reset and recovery windows. Gates writes from the AXI receive path against `almost_full`. Converts the FIFO's two-cycle registered read into a valid/ready stream for the core, using a small credit-managed output buffer.

## Interface
- `DATA_W`, 32: data width.
- `RST_CYCLES`, 5: cycles `fifo_rst` is held high per reset sequence.
- `RST_WAIT`, 5: idle cycles after `fifo_rst` falls before any `fifo_we`/`fifo_re`.
- `READ_LAT`, 2: `fifo_re` to valid `fifo_dout`, in cycles.
- `BUF_DEPTH`, 4: output buffer entries; must be ≥ `READ_LAT`+2.

- `clk` in 1: single clock for the controller and the FIFO.
- `rst_n` in 1: asynchronous, active-low reset.
- `flush` in 1: synchronous request to empty the FIFO and buffer; sampled only in RUN.
- `s_valid` in 1, `s_data` in DATA_W, `s_ready` out 1: write-side stream.
- `m_valid` out 1, `m_data` out DATA_W, `m_ready` in 1: read-side stream to the core.
- `fifo_rst` out 1, `fifo_we` out 1, `fifo_din` out DATA_W, `fifo_re` out 1: FIFO controls.
- `fifo_dout` in DATA_W, `fifo_empty` in 1, `fifo_almost_full` in 1: FIFO status and data.
- `busy` out 1: high whenever the state is not RUN.

## Operation
- **States:** RST_ASSERT, RST_WAIT, RUN.
  - RST_ASSERT: `fifo_rst`=1. Go to RST_WAIT after `RST_CYCLES` cycles.
  - RST_WAIT: `fifo_rst`=0. Go to RUN after `RST_WAIT` cycles.
  - RUN: normal operation. `flush`=1 goes to RST_ASSERT.
  - One down-counter, reloaded on every state entry.
- **Reset values (`rst_n`=0):**
  - State RST_ASSERT with counter loaded, so a full reset sequence runs after release.
  - `fifo_rst`=1, `busy`=1.
  - `fifo_we`=0, `fifo_re`=0, `s_ready`=0, `m_valid`=0.
  - Buffer count=0, in-flight vector=0, `m_data`=0.
- **Write path:**
  - `s_ready` = RUN & !`fifo_almost_full`.
  - `fifo_we` = `s_valid` & `s_ready`.
  - `fifo_din` = `s_data`, combinational passthrough.
  - `fifo_we` is never high outside RUN.
- **Read issue:**
  - `fifo_re` = RUN & !`fifo_empty` & (count + inflight) < `BUF_DEPTH`.
  - `inflight` = popcount of the `READ_LAT`-bit in-flight shift vector.
  - `fifo_re` is never asserted while `fifo_empty`=1, so RDERR never fires.
- **In-flight tracking:**
  - Each cycle the vector shifts left and bit 0 takes `fifo_re`.
  - When bit `READ_LAT`-1 is high, `fifo_dout` is pushed into the buffer at that edge.
- **Output buffer:**
  - Circular, `BUF_DEPTH` entries, with write pointer, read pointer and count.
  - `m_valid` = count≠0. `m_data` = entry at the read pointer.
  - Pop on `m_valid` & `m_ready`.
  - Push and pop in the same cycle leave count unchanged and advance both pointers.
  - Pointers wrap modulo `BUF_DEPTH`.
- **Flush:**
  - On entry to RST_ASSERT from RUN, in the same edge: clear count, pointers and in-flight vector.
  - Read data already in flight is discarded.
  - `m_valid` falls the cycle after `flush` is sampled.
- **Simultaneous `flush` and `m_valid` & `m_ready`:** the transfer completes; everything else is discarded.

## Timing
- **After `rst_n` release:** `busy` stays 1 for `RST_CYCLES`+`RST_WAIT` cycles (10 by default). `s_ready` can first be 1 in cycle 11.
- **Read latency:**
  - `fifo_re` high in cycle t → `fifo_dout` captured at the end of cycle t+`READ_LAT`.
  - `m_valid` is high in cycle t+`READ_LAT`+1.
- **Throughput:** with `m_ready` held at 1 and the FIFO non-empty, `fifo_re` sustains 1 word per cycle, so `m_valid` stays high continuously.
- **Stall:** with `m_ready`=0, at most `BUF_DEPTH` words are captured. `fifo_re` deasserts once count + inflight reaches `BUF_DEPTH`. No word is lost or duplicated.
- **`flush` held high:** the controller re-enters RST_ASSERT after each RUN cycle in which `flush` is sampled.
- **Mid-sequence `rst_n` assertion:** asynchronously returns to the reset values.

## Test plan
- **Reset sequence:** release `rst_n` → `fifo_rst`=1 for 5 cycles, then 0, `busy`=1 for 10 cycles. `fifo_we`/`fifo_re` are 0 throughout; `s_ready` rises in cycle 11.
- **Single word:** write 0xDEADBEEF with `m_ready`=1 → exactly one `m_valid` beat carrying 0xDEADBEEF. `fifo_re` to `m_valid` is 3 cycles.
- **Burst:** write 64 incrementing words with `m_ready`=1 → 64 in-order beats, no gaps once streaming, and `fifo_re` never asserted while `fifo_empty`=1.
- **Backpressure:** hold `m_ready`=0 and write 600 words → `s_ready` falls when `almost_full` asserts, and the buffer count saturates at 4. Release `m_ready` → all accepted words arrive in order.
- **Flush mid-burst:** assert `flush` for 1 cycle with 2 reads in flight → `m_valid`=0 next cycle, the in-flight words never appear, and the 10-cycle reset sequence repeats. A new word 0x1234 written afterwards is the first beat out.
- **Async reset mid-stream:** pull `rst_n` low mid-stream → outputs take their reset values immediately, no stale beat appears after release, and the reset sequence reruns.

Source files
------------

// File: rtl/rx_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// rx_fifo_ctrl
//
// Controller for the receive FIFO. The FIFO is a FIFO18E1 in synchronous mode,
// 36 bits wide, non-FWFT, with its output register enabled.
//   - Runs the FIFO's reset pulse and the recovery window that must follow it.
//   - Gates writes from the receive path against almost_full.
//   - Converts the FIFO's registered read (READ_LAT cycles) into a valid/ready
//     stream. A small output buffer gives credit to reads that are still in
//     flight, so a stalled consumer never loses a word.
//
// Parameters
//   DATA_W      data width
//   RST_CYCLES  cycles fifo_rst is held high in each reset sequence (>= 1)
//   RST_WAIT    idle cycles after fifo_rst falls, before any access (>= 1)
//   READ_LAT    cycles from fifo_re to valid fifo_dout (>= 1)
//   BUF_DEPTH   output buffer entries; must be >= READ_LAT + 2
//
// Ports
//   clk, rst_n                   clock; asynchronous active-low reset
//   flush                        request to empty the FIFO and buffer (RUN only)
//   s_valid, s_data, s_ready     write-side stream from the receive path
//   m_valid, m_data, m_ready     read-side stream to the core
//   fifo_rst, fifo_we, fifo_din  FIFO reset and write controls
//   fifo_re                      FIFO read enable
//   fifo_dout, fifo_empty,       FIFO read data and status
//   fifo_almost_full
//   busy                         high whenever the controller is not in RUN
// -----------------------------------------------------------------------------
module rx_fifo_ctrl #(
    parameter int DATA_W     = 32,
    parameter int RST_CYCLES = 5,
    parameter int RST_WAIT   = 5,
    parameter int READ_LAT   = 2,
    parameter int BUF_DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    input  logic              m_ready,
    output logic              fifo_rst,
    output logic              fifo_we,
    output logic [DATA_W-1:0] fifo_din,
    output logic              fifo_re,
    input  logic [DATA_W-1:0] fifo_dout,
    input  logic              fifo_empty,
    input  logic              fifo_almost_full,
    output logic              busy
);

    localparam int CNT_MAX = (RST_CYCLES > RST_WAIT) ? RST_CYCLES : RST_WAIT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int PTR_W   = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int FILL_W  = $clog2(BUF_DEPTH + 1);
    localparam int OCC_W   = $clog2(BUF_DEPTH + READ_LAT + 1);

    localparam logic [CNT_W-1:0] RST_LOAD  = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(RST_WAIT - 1);

    typedef enum logic [1:0] {
        ST_RST_ASSERT,
        ST_RST_WAIT,
        ST_RUN
    } state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              in_run;
    logic              flush_take;

    logic [READ_LAT-1:0] flight;     // one bit per read still inside the FIFO
    logic [OCC_W-1:0]    inflight;
    logic [FILL_W-1:0]   count;
    logic [PTR_W-1:0]    wptr, rptr;
    logic [DATA_W-1:0]   buf_mem [BUF_DEPTH];
    logic                push, pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // ---------------- sequencing FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignment, so every flop samples pre-edge values regardless of process order.
        if (!rst_n) begin
            state <= ST_RST_ASSERT;
            cnt   <= RST_LOAD;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        // NOTE: each signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
        state_nxt  = state;
        cnt_nxt    = cnt;
        flush_take = 1'b0;
        in_run     = 1'b0;
        fifo_rst   = 1'b0;
        case (state)
            ST_RST_ASSERT: begin
                fifo_rst = 1'b1;
                if (cnt == '0) begin
                    state_nxt = ST_RST_WAIT;
                    cnt_nxt   = WAIT_LOAD;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            ST_RST_WAIT: begin
                if (cnt == '0) begin
                    state_nxt = ST_RUN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            ST_RUN: begin
                in_run = 1'b1;
                if (flush) begin
                    state_nxt  = ST_RST_ASSERT;
                    cnt_nxt    = RST_LOAD;
                    flush_take = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_RST_ASSERT;
                cnt_nxt   = RST_LOAD;
            end
        endcase
    end

    assign busy = !in_run;

    // ---------------- write path ----------------
    assign s_ready  = in_run && !fifo_almost_full;
    assign fifo_we  = s_valid && s_ready;
    assign fifo_din = s_data;

    // ---------------- read issue ----------------
    // A read is issued only when the buffer can hold its word along with every
    // word already in flight, so the registered FIFO output never needs a stall.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < READ_LAT; i++) begin
            inflight = inflight + OCC_W'(flight[i]);
        end
    end

    assign fifo_re = in_run && !fifo_empty
                     && ((OCC_W'(count) + inflight) < OCC_W'(BUF_DEPTH));

    // ---------------- output buffer ----------------
    assign push    = flight[READ_LAT-1];
    assign m_valid = (count != '0);
    assign pop     = m_valid && m_ready;
    assign m_data  = buf_mem[rptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flight <= '0;
            count  <= '0;
            wptr   <= '0;
            rptr   <= '0;
            // NOTE: the buffer is a handful of flops, reset so m_data is defined (zero) out of reset rather than X.
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_mem[i] <= '0;
            end
        end else if (flush_take) begin
            // Reads still in flight are dropped; a pop this cycle has already
            // completed at the interface, so clearing the count is enough.
            flight <= '0;
            count  <= '0;
            wptr   <= '0;
            rptr   <= '0;
        end else begin
            flight <= (flight << 1) | READ_LAT'(fifo_re);
            if (push) begin
                buf_mem[wptr] <= fifo_dout;
                wptr          <= ptr_inc(wptr);
            end
            if (pop) begin
                rptr <= ptr_inc(rptr);
            end
            case ({push, pop})
                2'b10:   count <= count + FILL_W'(1);
                2'b01:   count <= count - FILL_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_rx_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rx_fifo_ctrl
//
// Directed bench for rx_fifo_ctrl. A behavioural FIFO (depth 512, almost_full
// at 500, two-cycle registered read) sits on the FIFO ports. Inputs are driven
// on the falling edge; outputs are sampled 1 ns later, and handshakes that will
// complete at the next rising edge are scored at that point. Words accepted on
// the write side go into a scoreboard queue, and every output beat is compared
// against the head of that queue.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_rx_fifo_ctrl;

    localparam int DATA_W     = 32;
    localparam int FIFO_DEPTH = 512;
    localparam int AF_LEVEL   = 500;

    logic              clk     = 1'b0;
    logic              rst_n   = 1'b0;
    logic              flush   = 1'b0;
    logic              s_valid = 1'b0;
    logic [DATA_W-1:0] s_data  = '0;
    logic              m_ready = 1'b0;
    logic              s_ready, m_valid, fifo_rst, fifo_we, fifo_re, busy;
    logic [DATA_W-1:0] m_data, fifo_din;
    logic [DATA_W-1:0] fifo_dout = '0;
    logic              fifo_empty, fifo_almost_full;

    always #5 clk = ~clk;

    rx_fifo_ctrl #(
        .DATA_W(DATA_W), .RST_CYCLES(5), .RST_WAIT(5), .READ_LAT(2), .BUF_DEPTH(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
        .fifo_rst(fifo_rst), .fifo_we(fifo_we), .fifo_din(fifo_din), .fifo_re(fifo_re),
        .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
        .fifo_almost_full(fifo_almost_full), .busy(busy)
    );

    // ---------------- behavioural FIFO ----------------
    logic [DATA_W-1:0] fmem [1024];
    int unsigned       wr_cnt = 0;
    int unsigned       rd_cnt = 0;
    logic [DATA_W-1:0] rd_stage = '0;

    assign fifo_empty       = (wr_cnt == rd_cnt);
    assign fifo_almost_full = ((wr_cnt - rd_cnt) >= AF_LEVEL);

    always @(posedge clk) begin
        if (fifo_rst) begin
            wr_cnt <= 0;
            rd_cnt <= 0;
        end else begin
            if (fifo_we) begin
                fmem[wr_cnt % 1024] <= fifo_din;
                wr_cnt <= wr_cnt + 1;
            end
            if (fifo_re) begin
                rd_stage <= fmem[rd_cnt % 1024];
                rd_cnt   <= rd_cnt + 1;
            end
        end
        fifo_dout <= rd_stage;
    end

    // ---------------- bench state ----------------
    int checks = 0;
    int errors = 0;
    logic [DATA_W-1:0] src_q [$];
    logic [DATA_W-1:0] exp_q [$];
    logic sink_rdy  = 1'b0;
    logic flush_req = 1'b0;
    int cyc = 0, beats = 0, gaps = 0;
    int re_err = 0, acc_err = 0, ovf = 0, af_err = 0;
    int re_cyc = -1, mv_cyc = -1;
    logic [DATA_W-1:0] first_beat = '0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // One clock cycle: drive at the falling edge, then score what the next
    // rising edge will commit.
    task automatic step();
        @(negedge clk);
        s_valid = (src_q.size() != 0);
        s_data  = s_valid ? src_q[0] : '0;
        m_ready = sink_rdy;
        flush   = flush_req;
        #1;
        cyc++;
        if (fifo_re && fifo_empty) re_err++;
        if (busy && (fifo_we || fifo_re)) acc_err++;
        if (s_ready && fifo_almost_full) af_err++;
        if (fifo_we && ((wr_cnt - rd_cnt) >= FIFO_DEPTH)) ovf++;
        if (fifo_re && re_cyc < 0) re_cyc = cyc;
        if (m_valid && mv_cyc < 0) mv_cyc = cyc;
        if (s_valid && s_ready) exp_q.push_back(src_q.pop_front());
        if (m_valid && m_ready) begin
            if (beats == 0) first_beat = m_data;
            beats++;
            if (exp_q.size() != 0) check("beat_data", m_data, exp_q.pop_front());
            else                   check("beat_unexpected", m_valid, 1'b0);
        end
        if (flush && !busy) exp_q.delete();
    endtask

    // Eleven cycles starting with the first cycle of a reset sequence.
    task automatic run_rst_seq(input string tag);
        int b0;
        b0 = beats;
        for (int k = 1; k <= 11; k++) begin
            step();
            check({tag, "_fifo_rst"}, fifo_rst, (k <= 5));
            check({tag, "_busy"},     busy,     (k <= 10));
            check({tag, "_s_ready"},  s_ready,  (k == 11));
            if (k <= 10) check({tag, "_m_valid"}, m_valid, 1'b0);
        end
        check({tag, "_no_beats"}, beats - b0, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---- reset values, with a word already offered ----
        src_q.push_back(32'hDEAD_BEEF);
        sink_rdy = 1'b1;
        repeat (3) step();
        check("rst_fifo_rst", fifo_rst, 1'b1);
        check("rst_busy",     busy,     1'b1);
        check("rst_s_ready",  s_ready,  1'b0);
        check("rst_fifo_we",  fifo_we,  1'b0);
        check("rst_fifo_re",  fifo_re,  1'b0);
        check("rst_m_valid",  m_valid,  1'b0);
        check("rst_m_data",   m_data,   32'h0);

        // ---- reset sequence, then the single word ----
        @(posedge clk); #1 rst_n = 1'b1;
        re_cyc = -1; mv_cyc = -1; beats = 0;
        run_rst_seq("seq");
        check("seq_first_we", fifo_we, 1'b1);
        repeat (20) step();
        check("single_beats", beats, 1);
        check("single_data",  first_beat, 32'hDEAD_BEEF);
        check("single_lat",   mv_cyc - re_cyc, 3);

        // ---- 64-word burst, streaming ----
        beats = 0; gaps = 0;
        for (int i = 0; i < 64; i++) src_q.push_back(32'h100 + i);
        for (int i = 0; i < 300 && beats < 64; i++) begin
            step();
            if (beats > 0 && beats < 64 && !m_valid) gaps++;
        end
        check("burst_beats", beats, 64);
        check("burst_gaps",  gaps, 0);
        check("burst_re_empty", re_err, 0);

        // ---- backpressure: 600 words against a stalled consumer ----
        beats = 0; sink_rdy = 1'b0;
        for (int i = 0; i < 600; i++) src_q.push_back(32'h1000 + i);
        repeat (560) step();
        check("bp_accepted", exp_q.size(), 504);
        check("bp_buf_count", dut.count, 4);
        check("bp_s_ready", s_ready, 1'b0);
        check("bp_fifo_re", fifo_re, 1'b0);
        check("bp_m_valid", m_valid, 1'b1);
        check("bp_beats",   beats, 0);
        sink_rdy = 1'b1;
        for (int i = 0; i < 3000 && (src_q.size() != 0 || exp_q.size() != 0); i++) step();
        check("bp_drain_beats", beats, 600);
        check("bp_drain_left",  exp_q.size() + src_q.size(), 0);
        check("bp_af_gate", af_err, 0);
        check("bp_overflow", ovf, 0);

        // ---- flush with two reads in flight ----
        beats = 0;
        for (int i = 0; i < 16; i++) src_q.push_back(32'h2000 + i);
        for (int i = 0; i < 100 && beats < 3; i++) step();
        check("flush_pre_beats", beats, 3);
        flush_req = 1'b1;
        src_q.delete();
        step();
        check("flush_inflight", dut.flight, 2'b11);
        flush_req = 1'b0;
        run_rst_seq("flush");
        beats = 0;
        src_q.push_back(32'h0000_1234);
        repeat (20) step();
        check("flush_next_beats", beats, 1);
        check("flush_next_data",  first_beat, 32'h0000_1234);

        // ---- asynchronous reset mid-stream ----
        beats = 0;
        for (int i = 0; i < 20; i++) src_q.push_back(32'h3000 + i);
        for (int i = 0; i < 100 && beats < 5; i++) step();
        check("arst_pre_beats", beats, 5);
        #1 rst_n = 1'b0;
        #1;
        src_q.delete();
        exp_q.delete();
        check("arst_fifo_rst", fifo_rst, 1'b1);
        check("arst_busy",     busy,     1'b1);
        check("arst_m_valid",  m_valid,  1'b0);
        check("arst_s_ready",  s_ready,  1'b0);
        check("arst_fifo_we",  fifo_we,  1'b0);
        check("arst_fifo_re",  fifo_re,  1'b0);
        check("arst_m_data",   m_data,   32'h0);
        @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
        beats = 0;
        run_rst_seq("arst");
        repeat (10) step();
        check("arst_no_stale", beats, 0);
        src_q.push_back(32'hCAFE_0001);
        repeat (20) step();
        check("arst_recover_beats", beats, 1);
        check("arst_recover_data",  first_beat, 32'hCAFE_0001);

        // ---- whole-run protocol monitors ----
        check("mon_re_while_empty", re_err, 0);
        check("mon_access_busy",    acc_err, 0);
        check("mon_af_gate",        af_err, 0);
        check("mon_overflow",       ovf, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
